// File: rtl/impl_window_checker.sv
// Multi-channel checker for trig |-> ##[MIN_DLY:MAX_DLY] resp.
// Per-channel pass/fail pulses, sticky errors, fail count, first failing channel.
module impl_window_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 2,
  parameter int CNT_W   = 8,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] trig_i,
  input  logic [NUM_CH-1:0] resp_i,
  output logic [NUM_CH-1:0] pass_o,
  output logic [NUM_CH-1:0] fail_o,
  output logic [NUM_CH-1:0] err_o,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic              first_vld_o,
  output logic [CH_W-1:0]   first_ch_o
);

  localparam int SUM_W = CNT_W + CH_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX =
    SUM_W'({CNT_W{1'b1}});

  logic [MAX_DLY:1]  p_q [NUM_CH];
  logic [MAX_DLY:1]  p_d [NUM_CH];
  logic [NUM_CH-1:0] t_v, r_v, imm_v;
  logic [NUM_CH-1:0] pass_q, pass_d;
  logic [NUM_CH-1:0] fail_q, exp_v;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fv_q, fv_d;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic [SUM_W-1:0]  sum;
  logic [CH_W-1:0]   low_ch;

  // Disabled channels are masked here so nothing downstream sees them.
  always_comb begin
    t_v   = trig_i & en_i;
    r_v   = resp_i & en_i;
    imm_v = (MIN_DLY == 0) ? (t_v & r_v) : '0;
    pass_d = '0;
    exp_v  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pass_d[c] = imm_v[c];
      for (int j = 1; j <= MAX_DLY; j++) begin
        if (j >= MIN_DLY)
          pass_d[c] = pass_d[c] | (p_q[c][j] & r_v[c]);
      end
      exp_v[c] = p_q[c][MAX_DLY] & ~r_v[c] & en_i[c];
      p_d[c] = '0;
      if (en_i[c] && !clr_i) begin
        p_d[c][1] = t_v[c] & ~imm_v[c];
        for (int j = 1; j < MAX_DLY; j++) begin
          p_d[c][j+1] = p_q[c][j] &
            ~(r_v[c] && (j >= MIN_DLY));
        end
      end
    end
  end

  always_comb begin
    sum = SUM_W'(cnt_q);
    for (int c = 0; c < NUM_CH; c++)
      sum = sum + SUM_W'(exp_v[c]);
    low_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (exp_v[c]) low_ch = CH_W'(c);
    end
    err_d = err_q | exp_v;
    cnt_d = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
    fv_d  = fv_q;
    fch_d = fch_q;
    if (!fv_q && (|exp_v)) begin
      fv_d  = 1'b1;
      fch_d = low_ch;
    end
    if (clr_i) begin
      err_d = '0;
      cnt_d = '0;
      fv_d  = 1'b0;
      fch_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++)
        p_q[c] <= '0;
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= '0;
      cnt_q  <= '0;
      fv_q   <= 1'b0;
      fch_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        p_q[c] <= p_d[c];
      pass_q <= pass_d;
      fail_q <= exp_v;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      fv_q   <= fv_d;
      fch_q  <= fch_d;
    end
  end

  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign err_o       = err_q;
  assign fail_cnt_o  = cnt_q;
  assign first_vld_o = fv_q;
  assign first_ch_o  = fch_q;

endmodule

// File: tb/tb_impl_window_checker.sv
// Scoreboard bench for impl_window_checker.
// Default build (A) and MIN_DLY=0, CNT_W=2 build (B).
module tb_impl_window_checker;

  typedef struct {
    int         id;
    logic [3:0] pass;
    logic [3:0] fail;
    logic [3:0] err;
    logic [7:0] cnt;
    logic       fv;
    logic [1:0] fch;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] en_a, trig_a, resp_a;
  logic       clr_a;
  logic [3:0] pass_a, fail_a, err_a;
  logic [7:0] cnt_a;
  logic       fv_a;
  logic [1:0] fch_a;

  logic [3:0] en_b, trig_b, resp_b;
  logic       clr_b;
  logic [3:0] pass_b, fail_b, err_b;
  logic [1:0] cnt_b;
  logic       fv_b;
  logic [1:0] fch_b;

  exp_t qa[$];
  exp_t qb[$];
  int n_vec = 0;
  int n_bad = 0;

  impl_window_checker u_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_a),
    .clr_i(clr_a), .trig_i(trig_a),
    .resp_i(resp_a), .pass_o(pass_a),
    .fail_o(fail_a), .err_o(err_a),
    .fail_cnt_o(cnt_a), .first_vld_o(fv_a),
    .first_ch_o(fch_a)
  );

  impl_window_checker #(
    .MIN_DLY(0), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_b),
    .clr_i(clr_b), .trig_i(trig_b),
    .resp_i(resp_b), .pass_o(pass_b),
    .fail_o(fail_b), .err_o(err_b),
    .fail_cnt_o(cnt_b), .first_vld_o(fv_b),
    .first_ch_o(fch_b)
  );

  task automatic cmp(input string nm, input int id,
                     input logic [22:0] act,
                     input logic [22:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s%0d: got pass=%b fail=%b err=%b cnt=%0d fv=%b fch=%0d, required pass=%b fail=%b err=%b cnt=%0d fv=%b fch=%0d",
        nm, id, act[22:19], act[18:15], act[14:11],
        act[10:3], act[2], act[1:0],
        req[22:19], req[18:15], req[14:11],
        req[10:3], req[2], req[1:0]);
    end
  endtask

  function automatic logic [22:0] pk(input exp_t e);
    return {e.pass, e.fail, e.err, e.cnt, e.fv, e.fch};
  endfunction

  always @(posedge clk) begin : mon_a
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      cmp("A", e.id,
        {pass_a, fail_a, err_a, cnt_a, fv_a, fch_a},
        pk(e));
    end
  end

  always @(posedge clk) begin : mon_b
    exp_t e;
    #1;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      cmp("B", e.id,
        {pass_b, fail_b, err_b, 6'd0, cnt_b, fv_b, fch_b},
        pk(e));
    end
  end

  task automatic step(input bit sel, input int id,
    input logic [3:0] en, input logic clr,
    input logic [3:0] trig, input logic [3:0] resp,
    input logic [3:0] ep, input logic [3:0] ef,
    input logic [3:0] ee, input logic [7:0] ec,
    input logic efv, input logic [1:0] efc);
    exp_t e;
    @(negedge clk);
    e.id = id; e.pass = ep; e.fail = ef;
    e.err = ee; e.cnt = ec; e.fv = efv; e.fch = efc;
    if (!sel) begin
      en_a = en; clr_a = clr;
      trig_a = trig; resp_a = resp;
      clr_b = 1'b0; trig_b = '0; resp_b = '0;
      qa.push_back(e);
    end else begin
      en_b = en; clr_b = clr;
      trig_b = trig; resp_b = resp;
      clr_a = 1'b0; trig_a = '0; resp_a = '0;
      qb.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 4'hF; clr_a = 1'b0; trig_a = '0; resp_a = '0;
    en_b = 4'hF; clr_b = 1'b0; trig_b = '0; resp_b = '0;
    #2;
    cmp("rstA", 0, {pass_a, fail_a, err_a, cnt_a, fv_a, fch_a}, '0);
    cmp("rstB", 0, {pass_b, fail_b, err_b, 6'd0, cnt_b, fv_b, fch_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // single attempt, pass at edge t+2
    step(0,  1, 4'hF,0,4'h1,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0,  2, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0,  3, 4'hF,0,4'h0,4'h1, 4'h1,4'h0,4'h0,8'd0,0,2'd0);
    step(0,  4, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    // trig held 4 cycles, one resp; last two attempts expire
    step(0,  5, 4'hF,0,4'h1,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0,  6, 4'hF,0,4'h1,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0,  7, 4'hF,0,4'h1,4'h1, 4'h1,4'h0,4'h0,8'd0,0,2'd0);
    step(0,  8, 4'hF,0,4'h1,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0,  9, 4'hF,0,4'h0,4'h0, 4'h0,4'h1,4'h1,8'd1,1,2'd0);
    step(0, 10, 4'hF,0,4'h0,4'h0, 4'h0,4'h1,4'h1,8'd2,1,2'd0);
    step(0, 11, 4'hF,1,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    // ch1 and ch2 fail together, lowest index captured
    step(0, 12, 4'hF,0,4'h6,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0, 13, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0, 14, 4'hF,0,4'h0,4'h0, 4'h0,4'h6,4'h6,8'd2,1,2'd1);
    // ch3 disabled mid-window, then re-enabled
    step(0, 15, 4'hF,0,4'h8,4'h0, 4'h0,4'h0,4'h6,8'd2,1,2'd1);
    step(0, 16, 4'h7,0,4'h0,4'h8, 4'h0,4'h0,4'h6,8'd2,1,2'd1);
    step(0, 17, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h6,8'd2,1,2'd1);
    step(0, 18, 4'hF,0,4'h8,4'h0, 4'h0,4'h0,4'h6,8'd2,1,2'd1);
    step(0, 19, 4'hF,0,4'h0,4'h8, 4'h8,4'h0,4'h6,8'd2,1,2'd1);
    // clear on the expiry edge
    step(0, 20, 4'hF,0,4'h1,4'h0, 4'h0,4'h0,4'h6,8'd2,1,2'd1);
    step(0, 21, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h6,8'd2,1,2'd1);
    step(0, 22, 4'hF,1,4'h0,4'h0, 4'h0,4'h1,4'h0,8'd0,0,2'd0);
    // trigger sampled with clear is dropped
    step(0, 23, 4'hF,1,4'h4,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0, 24, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0, 25, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);

    // B: same-edge pass, saturating counter
    step(1,  1, 4'hF,0,4'h1,4'h1, 4'h1,4'h0,4'h0,8'd0,0,2'd0);
    step(1,  2, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(1,  3, 4'hF,0,4'h3,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(1,  4, 4'hF,0,4'hF,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(1,  5, 4'hF,0,4'h0,4'h0, 4'h0,4'h3,4'h3,8'd2,1,2'd0);
    step(1,  6, 4'hF,0,4'h0,4'h0, 4'h0,4'hF,4'hF,8'd3,1,2'd0);
    step(1,  7, 4'hF,0,4'h1,4'h0, 4'h0,4'h0,4'hF,8'd3,1,2'd0);
    step(1,  8, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'hF,8'd3,1,2'd0);
    step(1,  9, 4'hF,0,4'h0,4'h0, 4'h0,4'h1,4'hF,8'd3,1,2'd0);
    step(1, 10, 4'hF,0,4'h2,4'h0, 4'h0,4'h0,4'hF,8'd3,1,2'd0);
    step(1, 11, 4'hF,0,4'h0,4'h2, 4'h2,4'h0,4'hF,8'd3,1,2'd0);

    // A: reset while ch2 attempt is in flight
    step(0, 26, 4'hF,0,4'h3,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0, 27, 4'hF,0,4'h4,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0, 28, 4'hF,0,4'h0,4'h0, 4'h0,4'h3,4'h3,8'd2,1,2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp("rstmidA", 28, {pass_a, fail_a, err_a, cnt_a, fv_a, fch_a}, '0);
    step(0, 29, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 30, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);
    step(0, 31, 4'hF,0,4'h0,4'h0, 4'h0,4'h0,4'h0,8'd0,0,2'd0);

    repeat (3) @(negedge clk);
    n_vec++;
    if (qa.size() + qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0",
        qa.size() + qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
